// File: rtl/f_stage_fetch.sv
// Fetch stage: PC generation, single-outstanding instruction-memory requests,
// a 2-entry instruction buffer and branch/jump redirects with one delay slot.
module f_stage_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRdata,
    output logic [31:0] InsOut,
    output logic [31:0] PCOut
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  occ_q, occ_d;
    logic        out_q, out_d;
    logic        drop_q, drop_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] ent0_ins_q, ent0_ins_d, ent0_pc_q, ent0_pc_d;
    logic [31:0] ent1_ins_q, ent1_ins_d, ent1_pc_q, ent1_pc_d;

    logic        ack_v, push, pop, out_rem, redir_acc, issue;
    logic        slot_head, slot_push, slot_out;
    logic [1:0]  occ_n;

    // Request/response: IMemReq is a one-cycle pulse carrying IMemAddr; each
    // request is answered by exactly one IMemAck (with IMemRdata) at least one
    // cycle later, in order. Only one request is ever outstanding.
    always_comb begin
        ack_v     = IMemAck && out_q;
        push      = ack_v && !drop_q;
        out_rem   = out_q && !ack_v;
        pop       = !Stall && (occ_q != 2'd0);
        redir_acc = !Stall && Redirect;

        // Where the delay slot lives: the head D just took, the word arriving
        // now, the live outstanding request, or (failing those) the next issue.
        slot_head = redir_acc && (occ_q != 2'd0);
        slot_push = redir_acc && (occ_q == 2'd0) && push;
        slot_out  = redir_acc && (occ_q == 2'd0) && !push && out_rem && !drop_q;

        ent0_ins_d = ent0_ins_q;
        ent0_pc_d  = ent0_pc_q;
        ent1_ins_d = ent1_ins_q;
        ent1_pc_d  = ent1_pc_q;
        occ_n      = occ_q;
        if (pop) begin
            ent0_ins_d = ent1_ins_q;
            ent0_pc_d  = ent1_pc_q;
            occ_n      = occ_q - 2'd1;
        end
        if (slot_head) begin
            occ_n = 2'd0;
        end else if (push) begin
            if (occ_n == 2'd0) begin
                ent0_ins_d = IMemRdata;
                ent0_pc_d  = out_addr_q;
            end else begin
                ent1_ins_d = IMemRdata;
                ent1_pc_d  = out_addr_q;
            end
            occ_n = occ_n + 2'd1;
        end
        occ_d = occ_n;

        // A fetch from the old PC after the delay slot is already held would be wrong-path.
        issue    = ResetN && !out_rem && (occ_n < DEPTH) && !slot_head && !slot_push;
        IMemReq  = issue;
        IMemAddr = pc_q;

        out_d      = out_rem || issue;
        out_addr_d = issue ? pc_q : out_addr_q;
        drop_d     = ack_v ? 1'b0 : drop_q;
        if (slot_head && out_rem) begin
            drop_d = 1'b1;
        end

        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (issue) begin
            pc_d   = pend_q ? pend_pc_q : pc_q + 32'd4;
            pend_d = 1'b0;
        end
        if (redir_acc) begin
            if (slot_head || slot_push || slot_out || issue) begin
                pc_d = RedirectPC;
            end else begin
                pend_d    = 1'b1;
                pend_pc_d = RedirectPC;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            pc_q       <= RESET_PC;
            occ_q      <= 2'd0;
            out_q      <= 1'b0;
            drop_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            out_addr_q <= '0;
            ent0_ins_q <= '0;
            ent0_pc_q  <= '0;
            ent1_ins_q <= '0;
            ent1_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            out_addr_q <= out_addr_d;
            ent0_ins_q <= ent0_ins_d;
            ent0_pc_q  <= ent0_pc_d;
            ent1_ins_q <= ent1_ins_d;
            ent1_pc_q  <= ent1_pc_d;
        end
    end

    assign InsOut = (occ_q != 2'd0) ? ent0_ins_q : 32'h0;
    assign PCOut  = (occ_q != 2'd0) ? ent0_pc_q  : 32'h0;

endmodule
